// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: funct3 codes, MMIO window
// defaults and the response-tracking record.
package dmem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1000_0000;
    localparam int unsigned MMIO_SIZE_DEFAULT = 1024;
    localparam int unsigned MMIO_ADDR_W       = 10;

    // byte_off rides along with the record so the load can be lane-shifted later
    typedef struct packed {
        logic       valid;
        logic       owner;
        logic       is_mmio;
        logic [2:0] funct3;
        logic       err;
        logic [1:0] byte_off;
    } resp_t;

    function automatic logic access_ok(input logic [2:0] funct3, input logic [1:0] byte_off);
        logic ok;
        case (funct3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = (byte_off[0] == 1'b0);
            F3_LW:         ok = (byte_off == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Lane-selects and sign/zero-extends a raw 32-bit memory word for a RISC-V load.
// Shared with the core's writeback stage.
module load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = raw >> {byte_off, 3'b000};
        data    = shifted;
        case (funct3)
            F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  data = {24'b0, shifted[7:0]};
            F3_LHU:  data = {16'b0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the shared data-memory / MMIO port.
// Optional MMIO decode is enabled by defining DMEM_ARB_MMIO_DECODE_EN.
module dmem_arbiter
    import dmem_pkg::*;
`ifdef DMEM_ARB_MMIO_DECODE_EN
#(
    parameter logic [31:0] MMIO_BASE_ADDR  = MMIO_BASE_DEFAULT,
    parameter int unsigned MMIO_SIZE_BYTES = MMIO_SIZE_DEFAULT
)
`endif
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   m0_req,
    input  logic                   m0_we,
    input  logic [31:0]            m0_addr,
    input  logic [31:0]            m0_wdata,
    input  logic [2:0]             m0_funct3,
    output logic                   m0_gnt,
    output logic                   m0_rvalid,
    output logic [31:0]            m0_rdata,
    output logic                   m0_err,
    input  logic                   m1_req,
    input  logic                   m1_we,
    input  logic [31:0]            m1_addr,
    input  logic [31:0]            m1_wdata,
    input  logic [2:0]             m1_funct3,
    output logic                   m1_gnt,
    output logic                   m1_rvalid,
    output logic [31:0]            m1_rdata,
    output logic                   m1_err,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [2:0]             mem_funct3,
`ifdef DMEM_ARB_MMIO_DECODE_EN
    output logic                   mmio_en,
    output logic                   mmio_we,
    output logic [MMIO_ADDR_W-1:0] mmio_addr,
    output logic [31:0]            mmio_wdata,
    output logic [2:0]             mmio_funct3,
    input  logic [31:0]            mmio_rdata,
`endif
    input  logic [31:0]            mem_rdata
);

    logic        rr_ptr;
    logic        contested;
    logic        grant;
    logic        sel;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [2:0]  cmd_funct3;
    logic        access_legal;
    logic        is_mmio_now;
    resp_t       resp_d;
    resp_t       resp_q;
    logic [31:0] mmio_raw;
    logic [31:0] raw_word;
    logic [31:0] ext_word;
    logic [31:0] rsp_data;
    logic        rsp_live;

    assign contested = m0_req && m1_req;

    // rr_ptr only decides contested cycles; a lone requester always wins
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!reset) begin
            if (contested) begin
                m0_gnt = ~rr_ptr;
                m1_gnt = rr_ptr;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    assign grant = m0_gnt || m1_gnt;
    assign sel   = m1_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (contested) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    always_comb begin
        cmd_we     = m0_we;
        cmd_addr   = m0_addr;
        cmd_wdata  = m0_wdata;
        cmd_funct3 = m0_funct3;
        if (sel) begin
            cmd_we     = m1_we;
            cmd_addr   = m1_addr;
            cmd_wdata  = m1_wdata;
            cmd_funct3 = m1_funct3;
        end
    end

    assign access_legal = access_ok(cmd_funct3, cmd_addr[1:0]);

`ifdef DMEM_ARB_MMIO_DECODE_EN
    // 33-bit window bounds so a window ending at 2^32 cannot wrap to zero
    localparam logic [32:0] WIN_LO = {1'b0, MMIO_BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + 33'(MMIO_SIZE_BYTES);

    assign is_mmio_now = ({1'b0, cmd_addr} >= WIN_LO) && ({1'b0, cmd_addr} < WIN_HI);
    assign mmio_en     = grant && access_legal && is_mmio_now;
    assign mmio_we     = mmio_en && cmd_we;
    assign mmio_addr   = cmd_addr[MMIO_ADDR_W-1:0];
    assign mmio_wdata  = cmd_wdata;
    assign mmio_funct3 = cmd_funct3;
    assign mmio_raw    = mmio_rdata;
`else
    assign is_mmio_now = 1'b0;
    assign mmio_raw    = '0;
`endif

    assign mem_en     = grant && access_legal && !is_mmio_now;
    assign mem_we     = mem_en && cmd_we;
    assign mem_addr   = cmd_addr;
    assign mem_wdata  = cmd_wdata;
    assign mem_funct3 = cmd_funct3;

    // Clean stores are tracked but not flagged valid; errors always report back
    always_comb begin
        resp_d = '0;
        if (grant) begin
            resp_d.valid    = !cmd_we || !access_legal;
            resp_d.owner    = sel;
            resp_d.is_mmio  = is_mmio_now;
            resp_d.funct3   = cmd_funct3;
            resp_d.err      = !access_legal;
            resp_d.byte_off = cmd_addr[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_q <= '0;
        end else begin
            resp_q <= resp_d;
        end
    end

    assign raw_word = resp_q.is_mmio ? mmio_raw : mem_rdata;

    load_extend u_load_extend (
        .raw      (raw_word),
        .funct3   (resp_q.funct3),
        .byte_off (resp_q.byte_off),
        .data     (ext_word)
    );

    assign rsp_live = resp_q.valid && !reset;
    assign rsp_data = resp_q.err ? 32'h0 : ext_word;

    assign m0_rvalid = rsp_live && !resp_q.owner;
    assign m1_rvalid = rsp_live && resp_q.owner;
    assign m0_rdata  = m0_rvalid ? rsp_data : 32'h0;
    assign m1_rdata  = m1_rvalid ? rsp_data : 32'h0;
    assign m0_err    = m0_rvalid && resp_q.err;
    assign m1_err    = m1_rvalid && resp_q.err;

endmodule
